// File: rtl/mxv_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mxv_frame_sequencer_if
// Brief    : UART RX handshake, memory write port, and compute control/status
//            bundle between the frame sequencer and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface mxv_frame_sequencer_if #(
  parameter int ADDR_W = 6
) ();
  logic              RXINT;
  logic [7:0]        RXDATA;
  logic              BUSY;
  logic              CLEARFLAG;
  logic              MATWE;
  logic              VECWE;
  logic [ADDR_W-1:0] WADDR;
  logic [7:0]        WDATA;
  logic [3:0]        NSIZE;
  logic              MATVALID;
  logic              VECVALID;
  logic              STARTOP;
  logic              ERRFLAG;
  logic              IDLEFLAG;

  // Sequencer side
  modport master (
    input  RXINT, RXDATA, BUSY,
    output CLEARFLAG, MATWE, VECWE, WADDR, WDATA, NSIZE,
           MATVALID, VECVALID, STARTOP, ERRFLAG, IDLEFLAG
  );

  // UART receiver / datapath side
  modport slave (
    output RXINT, RXDATA, BUSY,
    input  CLEARFLAG, MATWE, VECWE, WADDR, WDATA, NSIZE,
           MATVALID, VECVALID, STARTOP, ERRFLAG, IDLEFLAG
  );
endinterface
`default_nettype wire

// File: rtl/mxv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mxv_frame_sequencer
// Brief    : Parses FE,L,CMD,payload,EF command frames from the UART receiver,
//            writes matrix/vector memory, commits N and launches the multiply.
// Revision : 1.0 - initial release
// ============================================================================
module mxv_frame_sequencer #(
  parameter int MAX_N  = 8,
  parameter int ADDR_W = 6
) (
  input  wire logic             clk,
  input  wire logic             reset,
  mxv_frame_sequencer_if.master bus
);

  localparam logic [3:0] S_W_HDR  = 4'd0;
  localparam logic [3:0] S_W_LEN  = 4'd1;
  localparam logic [3:0] S_W_CMD  = 4'd2;
  localparam logic [3:0] S_W_PAY  = 4'd3;
  localparam logic [3:0] S_W_STOP = 4'd4;
  localparam logic [3:0] S_CLR    = 4'd5;
  localparam logic [3:0] S_DONE   = 4'd6;
  localparam logic [3:0] S_FAIL   = 4'd7;

  localparam logic [7:0] HDR_BYTE    = 8'hFE;
  localparam logic [7:0] STOP_BYTE   = 8'hEF;
  localparam logic [7:0] CMD_SETN    = 8'h01;
  localparam logic [7:0] CMD_START   = 8'h03;
  localparam logic [7:0] CMD_LOADMAT = 8'h04;
  localparam logic [7:0] CMD_LOADVEC = 8'h05;
  localparam logic [7:0] MAX_N_B     = 8'(MAX_N);
  localparam logic [3:0] RESET_N     = 4'(MAX_N);

  logic [3:0]        r_state, w_state_nxt;
  logic [3:0]        r_ret, w_ret_nxt;       // wait state to resume after CLR
  logic [7:0]        r_len, r_cmd, r_cnt, r_npend, r_wdata;
  logic [ADDR_W-1:0] r_waddr;
  logic [3:0]        r_nsize;
  logic              r_clear, r_matwe, r_vecwe, r_matv, r_vecv;
  logic              r_start, r_err, r_idle;

  logic [7:0] w_nsq, w_req_len;
  logic       w_known, w_cmd_ok, w_pay_last, w_done_ok;
  logic       w_pay_wr, w_commit;
  logic       w_clear_nxt, w_matwe_nxt, w_vecwe_nxt, w_err_nxt, w_idle_nxt, w_start_nxt;

  assign w_nsq      = {4'd0, r_nsize} * {4'd0, r_nsize};
  assign w_cmd_ok   = w_known && (r_len == w_req_len) &&
                      (!bus.BUSY || (bus.RXDATA == CMD_START));
  assign w_pay_last = (r_cnt == (r_len - 8'd2));

  // Frame length each command must carry, for the CMD byte on the bus
  always_comb begin
    w_known   = 1'b1;
    w_req_len = 8'd0;
    case (bus.RXDATA)
      CMD_SETN:    w_req_len = 8'd2;
      CMD_START:   w_req_len = 8'd1;
      CMD_LOADMAT: w_req_len = w_nsq + 8'd1;
      CMD_LOADVEC: w_req_len = {4'd0, r_nsize} + 8'd1;
      default:     w_known   = 1'b0;
    endcase
  end

  // Whether the command held in DONE may commit (BUSY sampled here for START)
  always_comb begin
    w_done_ok = 1'b0;
    case (r_cmd)
      CMD_SETN:    w_done_ok = (r_npend != 8'd0) && (r_npend <= MAX_N_B);
      CMD_START:   w_done_ok = r_matv && r_vecv && !bus.BUSY;
      CMD_LOADMAT: w_done_ok = 1'b1;
      CMD_LOADVEC: w_done_ok = 1'b1;
      default:     w_done_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_W_HDR;
      r_ret   <= S_W_HDR;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  // Next state: every accepted byte passes through CLR before the next wait
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    case (r_state)
      S_W_HDR: if (bus.RXINT) begin
        w_state_nxt = S_CLR;
        w_ret_nxt   = (bus.RXDATA == HDR_BYTE) ? S_W_LEN : S_W_HDR;
      end
      S_W_LEN: if (bus.RXINT) begin
        w_state_nxt = S_CLR;
        w_ret_nxt   = S_W_CMD;
      end
      S_W_CMD: if (bus.RXINT) begin
        w_state_nxt = S_CLR;
        if (!w_cmd_ok)            w_ret_nxt = S_FAIL;
        else if (r_len == 8'd1)   w_ret_nxt = S_W_STOP;
        else                      w_ret_nxt = S_W_PAY;
      end
      S_W_PAY: if (bus.RXINT) begin
        w_state_nxt = S_CLR;
        w_ret_nxt   = w_pay_last ? S_W_STOP : S_W_PAY;
      end
      S_W_STOP: if (bus.RXINT) begin
        w_state_nxt = S_CLR;
        w_ret_nxt   = (bus.RXDATA == STOP_BYTE) ? S_DONE : S_FAIL;
      end
      S_CLR:   w_state_nxt = r_ret;
      S_DONE:  w_state_nxt = w_done_ok ? S_W_HDR : S_FAIL;
      S_FAIL:  w_state_nxt = S_W_HDR;
      default: w_state_nxt = S_W_HDR;
    endcase
  end

  // Output decode, one cycle ahead so every strobe leaves from a flop
  always_comb begin
    w_pay_wr    = (r_state == S_W_PAY) && bus.RXINT;
    w_commit    = (r_state == S_DONE) && w_done_ok;
    w_clear_nxt = (w_state_nxt == S_CLR);
    w_matwe_nxt = w_pay_wr && (r_cmd == CMD_LOADMAT);
    w_vecwe_nxt = w_pay_wr && (r_cmd == CMD_LOADVEC);
    w_err_nxt   = (w_state_nxt == S_FAIL);
    w_idle_nxt  = (w_state_nxt == S_W_HDR);
    w_start_nxt = w_commit && (r_cmd == CMD_START);
  end

  // Frame fields, write port and committed status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len   <= 8'd0;
      r_cmd   <= 8'd0;
      r_cnt   <= 8'd0;
      r_npend <= 8'd0;
      r_wdata <= 8'd0;
      r_waddr <= '0;
      r_nsize <= RESET_N;
      r_matv  <= 1'b0;
      r_vecv  <= 1'b0;
      r_clear <= 1'b0;
      r_matwe <= 1'b0;
      r_vecwe <= 1'b0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      r_clear <= w_clear_nxt;
      r_matwe <= w_matwe_nxt;
      r_vecwe <= w_vecwe_nxt;
      r_err   <= w_err_nxt;
      r_start <= w_start_nxt;
      r_idle  <= w_idle_nxt;
      if ((r_state == S_W_LEN) && bus.RXINT) r_len <= bus.RXDATA;
      if ((r_state == S_W_CMD) && bus.RXINT) begin
        r_cmd <= bus.RXDATA;
        r_cnt <= 8'd0;
      end
      if (w_pay_wr) begin
        r_wdata <= bus.RXDATA;
        r_waddr <= ADDR_W'(r_cnt);
        r_cnt   <= r_cnt + 8'd1;
        if (r_cmd == CMD_SETN) r_npend <= bus.RXDATA;
      end
      // Memory becomes stale as soon as its first word is overwritten
      if (w_matwe_nxt) r_matv <= 1'b0;
      if (w_vecwe_nxt) r_vecv <= 1'b0;
      if (w_commit) begin
        case (r_cmd)
          CMD_SETN: begin
            r_nsize <= r_npend[3:0];
            r_matv  <= 1'b0;
            r_vecv  <= 1'b0;
          end
          CMD_LOADMAT: r_matv <= 1'b1;
          CMD_LOADVEC: r_vecv <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.CLEARFLAG = r_clear;
  assign bus.MATWE     = r_matwe;
  assign bus.VECWE     = r_vecwe;
  assign bus.WADDR     = r_waddr;
  assign bus.WDATA     = r_wdata;
  assign bus.NSIZE     = r_nsize;
  assign bus.MATVALID  = r_matv;
  assign bus.VECVALID  = r_vecv;
  assign bus.STARTOP   = r_start;
  assign bus.ERRFLAG   = r_err;
  assign bus.IDLEFLAG  = r_idle;

endmodule
`default_nettype wire
